// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// synchronizer depth, bus bit constants and the glitch-filter majority helper.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

    localparam int unsigned SyncStages = 2;

    localparam logic AckBit  = 1'b0;
    localparam logic NackBit = 1'b1;
    localparam logic RwRead  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_target_linesync.sv
// SCL/SDA pad conditioning: synchronizer, optional 3-sample majority filter
// (I2C_TARGET_GLITCH_FILTER_EN), and registered rise/fall/START/STOP strobes.
module i2c_target_linesync
    import i2c_target_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_line_o
);

    logic [SyncStages-1:0] scl_sync_q;
    logic [SyncStages-1:0] sda_sync_q;
    logic                  scl_line;
    logic                  sda_line;
    logic                  scl_prev_q;
    logic                  sda_prev_q;

    // Reset to the idle-bus level so release never fabricates an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SyncStages-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SyncStages-2:0], sda_i};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q;
    logic [1:0] sda_hist_q;
    logic       scl_filt_q;
    logic       sda_filt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[SyncStages-1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[SyncStages-1]};
            scl_filt_q <= maj3(scl_sync_q[SyncStages-1], scl_hist_q[0], scl_hist_q[1]);
            sda_filt_q <= maj3(sda_sync_q[SyncStages-1], sda_hist_q[0], sda_hist_q[1]);
        end
    end

    assign scl_line = scl_filt_q;
    assign sda_line = sda_filt_q;
`else
    assign scl_line = scl_sync_q[SyncStages-1];
    assign sda_line = sda_sync_q[SyncStages-1];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_o <= 1'b0;
            scl_fall_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
        end else begin
            scl_prev_q <= scl_line;
            sda_prev_q <= sda_line;
            scl_rise_o <= scl_line & ~scl_prev_q;
            scl_fall_o <= ~scl_line & scl_prev_q;
            start_o    <= scl_line & scl_prev_q & sda_prev_q & ~sda_line;
            stop_o     <= scl_line & scl_prev_q & ~sda_prev_q & sda_line;
        end
    end

    // Aligned with the strobes: the SDA level seen when the edge was detected.
    assign sda_line_o = sda_prev_q;

endmodule

// File: rtl/i2c_target.sv
// Byte-oriented I2C target with a NumRegs x 8 register file and shared pointer.
// Build option I2C_TARGET_GLITCH_FILTER_EN adds a majority filter on SCL/SDA.
//
// state        | meaning
// ST_IDLE      | bus free or not addressed
// ST_ADDR      | shifting address + R/W
// ST_ADDR_ACK  | driving ACK for the address byte
// ST_WR_BYTE   | receiving pointer or data byte
// ST_WR_ACK    | driving ACK for a received byte
// ST_RD_BYTE   | presenting regs[ptr] MSB first
// ST_RD_ACK    | sampling initiator ACK/NACK
// ST_WAIT_STOP | released, waiting for START/STOP
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  Addr    = 7'h42,
    parameter int unsigned NumRegs = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       scl_i,
    input  logic                       sda_i,
    output logic                       sda_oe_o,
    output logic                       sda_o,
    output logic [8*NumRegs-1:0]       regs_o,
    output logic                       wr_pulse_o,
    output logic [$clog2(NumRegs)-1:0] wr_idx_o,
    output logic                       busy_o
);

    localparam int unsigned IdxW = $clog2(NumRegs);

    logic scl_rise, scl_fall, bus_start, bus_stop, sda_line;

    i2c_target_linesync u_linesync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (bus_start),
        .stop_o     (bus_stop),
        .sda_line_o (sda_line)
    );

    i2c_state_e      state_q, state_d;
    logic [6:0]      shift_q, shift_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic            first_q, first_d;
    logic            nomatch_q, nomatch_d;
    logic            sda_oe_q, sda_oe_d;
    logic            wr_pulse_q, wr_pulse_d;
    logic [IdxW-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]      regs_q [NumRegs];
    logic [7:0]      regs_d [NumRegs];
    logic [7:0]      byte_in;

    assign byte_in = {shift_q, sda_line};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            first_q    <= 1'b0;
            nomatch_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
            regs_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            first_q    <= first_d;
            nomatch_q  <= nomatch_d;
            sda_oe_q   <= sda_oe_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        first_d    = first_q;
        nomatch_d  = nomatch_q;
        sda_oe_d   = sda_oe_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx_q;
        regs_d     = regs_q;

        if (bus_stop) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            nomatch_d = 1'b0;
        end else if (bus_start) begin
            state_d   = ST_ADDR;
            cnt_d     = '0;
            sda_oe_d  = 1'b0;
            nomatch_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d = byte_in[6:0];
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (shift_q == Addr) begin
                            state_d = ST_ADDR_ACK;
                            first_d = 1'b1;
                        end else begin
                            state_d   = ST_WAIT_STOP;
                            nomatch_d = 1'b1;
                        end
                    end
                end
                // sda_oe_q doubles as the phase flag: first fall drives ACK, second ends the slot.
                ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = ~AckBit;
                    end else begin
                        cnt_d = '0;
                        if (state_q == ST_ADDR_ACK && shift_q[0] == RwRead) begin
                            state_d  = ST_RD_BYTE;
                            shift_d  = regs_q[ptr_q][6:0];
                            sda_oe_d = ~regs_q[ptr_q][7];
                        end else begin
                            state_d  = ST_WR_BYTE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_WR_BYTE: if (scl_rise) begin
                    shift_d = byte_in[6:0];
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = ST_WR_ACK;
                        if (first_q) begin
                            ptr_d   = byte_in[IdxW-1:0];
                            first_d = 1'b0;
                        end else begin
                            regs_d[ptr_q] = byte_in;
                            wr_pulse_d    = 1'b1;
                            wr_idx_d      = ptr_q;
                            ptr_d         = ptr_q + 1'b1;
                        end
                    end
                end
                ST_RD_BYTE: if (scl_fall) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d  = ST_RD_ACK;
                        sda_oe_d = 1'b0;
                        ptr_d    = ptr_q + 1'b1;
                    end else begin
                        shift_d  = {shift_q[5:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_line == NackBit) begin
                            state_d = ST_WAIT_STOP;
                        end
                    end else if (scl_fall) begin
                        state_d  = ST_RD_BYTE;
                        cnt_d    = '0;
                        shift_d  = regs_q[ptr_q][6:0];
                        sda_oe_d = ~regs_q[ptr_q][7];
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NumRegs; k++) begin : g_regs
        assign regs_o[8*k +: 8] = regs_q[k];
    end

    assign sda_oe_o   = sda_oe_q;
    assign sda_o      = 1'b0;
    assign wr_pulse_o = wr_pulse_q;
    assign wr_idx_o   = wr_idx_q;
    assign busy_o     = (state_q != ST_IDLE) && !(state_q == ST_WAIT_STOP && nomatch_q);

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: drives an I2C initiator on a wired-AND bus and
// checks against a transaction-level register/pointer model.
module tb_i2c_target;

    localparam int CLK = 10;
    localparam int Q   = 10 * CLK;
    localparam logic [6:0] TGT = 7'h42;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        scl;
    logic        sda_tb;
    logic        sda_bus;
    logic        sda_oe_o;
    logic        sda_o;
    logic [31:0] regs_o;
    logic        wr_pulse_o;
    logic [1:0]  wr_idx_o;
    logic        busy_o;

    assign sda_bus = sda_tb & ~sda_oe_o;

    always #(CLK/2) clk = ~clk;

    i2c_target #(.Addr(TGT), .NumRegs(4)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .scl_i      (scl),
        .sda_i      (sda_bus),
        .sda_oe_o   (sda_oe_o),
        .sda_o      (sda_o),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o),
        .wr_idx_o   (wr_idx_o),
        .busy_o     (busy_o)
    );

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        exp_e;
    logic [7:0] model_regs [4];
    logic [1:0] model_ptr;
    int         npass = 0;
    int         nchecks = 0;
    int         pulse_cnt = 0;
    bit         checking = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nchecks++;
        if (act === req) npass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    function automatic logic [31:0] model_flat();
        return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
    endfunction

    // Every cycle: pulses must match queued writes, and regs_o must equal the model.
    always @(posedge clk) begin
        #1;
        if (checking) begin
            if (wr_pulse_o) begin
                pulse_cnt++;
                if (exp_q.size() == 0) begin
                    check("spurious wr_pulse", {31'd0, wr_pulse_o}, 32'd0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("wr_idx", {30'd0, wr_idx_o}, {30'd0, exp_e.idx});
                    model_regs[exp_e.idx] = exp_e.data;
                end
            end
            check("regs_o vs model", regs_o, model_flat());
        end
    end

    task automatic send_bit(input logic b, input logic glitch);
        sda_tb = b;
        #(Q);
        scl = 1'b1;
        if (glitch) begin
            #(Q);
            scl = 1'b0;
            #(CLK);
            scl = 1'b1;
            #(Q - CLK);
        end else begin
            #(2*Q);
        end
        scl = 1'b0;
        #(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_tb = 1'b1;
        #(Q);
        scl = 1'b1;
        #(Q);
        b = sda_bus;
        #(Q);
        scl = 1'b0;
        #(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_bit);
        recv_bit(ack);
    endtask

    task automatic bus_start();
        sda_tb = 1'b1;
        #(Q);
        scl = 1'b1;
        #(Q);
        sda_tb = 1'b0;
        #(Q);
        scl = 1'b0;
        #(Q);
    endtask

    task automatic bus_stop();
        sda_tb = 1'b0;
        #(Q);
        scl = 1'b1;
        #(Q);
        sda_tb = 1'b1;
        #(Q);
    endtask

    task automatic write_regs(input logic [7:0] ptr, input int n, input logic [7:0] d0,
                              input logic [7:0] d1, input bit stop_after, input int glitch_bit);
        logic ack;
        logic [7:0] d;
        bus_start();
        send_byte({TGT, 1'b0}, -1, ack);
        check("addr ack (write)", {31'd0, ack}, 32'd0);
        check("busy after address", {31'd0, busy_o}, 32'd1);
        send_byte(ptr, -1, ack);
        check("ptr ack", {31'd0, ack}, 32'd0);
        model_ptr = ptr[1:0];
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? d0 : d1;
            exp_q.push_back('{idx: model_ptr, data: d});
            model_ptr = model_ptr + 2'd1;
            send_byte(d, (i == 0) ? glitch_bit : -1, ack);
            check("data ack", {31'd0, ack}, 32'd0);
        end
        if (stop_after) begin
            bus_stop();
            check("busy after stop", {31'd0, busy_o}, 32'd0);
        end
    endtask

    task automatic read_regs(input int n, output logic [7:0] b0, output logic [7:0] b1);
        logic ack;
        logic bt;
        logic [7:0] rd;
        b0 = '0;
        b1 = '0;
        bus_start();
        send_byte({TGT, 1'b1}, -1, ack);
        check("addr ack (read)", {31'd0, ack}, 32'd0);
        for (int k = 0; k < n; k++) begin
            for (int i = 7; i >= 0; i--) begin
                recv_bit(bt);
                rd[i] = bt;
            end
            check("read byte vs model", {24'd0, rd}, {24'd0, model_regs[model_ptr]});
            model_ptr = model_ptr + 2'd1;
            if (k == 0) b0 = rd; else b1 = rd;
            send_bit((k == n - 1) ? 1'b1 : 1'b0, 1'b0);
        end
        check("sda released after nack", {31'd0, sda_oe_o}, 32'd0);
        check("busy before stop", {31'd0, busy_o}, 32'd1);
        bus_stop();
        check("busy after read stop", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        logic ack;
        logic [7:0] r0, r1;
        int exp_pulses;
        rst_ni = 1'b1;
        scl    = 1'b1;
        sda_tb = 1'b1;
        model_regs = '{default: '0};
        model_ptr  = '0;
        exp_pulses = 5;
        #(2*CLK);
        rst_ni = 1'b0;
        #(10*CLK);
        check("reset regs_o", regs_o, 32'd0);
        check("reset sda_oe_o", {31'd0, sda_oe_o}, 32'd0);
        check("reset wr_pulse_o", {31'd0, wr_pulse_o}, 32'd0);
        check("reset wr_idx_o", {30'd0, wr_idx_o}, 32'd0);
        check("reset busy_o", {31'd0, busy_o}, 32'd0);
        check("sda_o tied low", {31'd0, sda_o}, 32'd0);
        rst_ni = 1'b1;
        #(10*CLK);
        checking = 1;

        // ptr 1, two data bytes
        write_regs(8'h01, 2, 8'hA5, 8'h3C, 1, -1);
        check("regs[1] literal", {24'd0, regs_o[15:8]}, 32'h0000_00A5);
        check("regs[2] literal", {24'd0, regs_o[23:16]}, 32'h0000_003C);

        // ptr 3 wraps to 0
        write_regs(8'h03, 2, 8'h11, 8'h22, 1, -1);
        check("regs after wrap literal", regs_o, 32'h113C_A522);

        // set ptr 2, repeated START, read two bytes
        write_regs(8'h02, 0, 8'h00, 8'h00, 0, -1);
        read_regs(2, r0, r1);
        check("read byte0 literal", {24'd0, r0}, 32'h0000_003C);
        check("read byte1 literal", {24'd0, r1}, 32'h0000_0011);

        // wrong address: no ACK, data ignored
        bus_start();
        send_byte({7'h43, 1'b0}, -1, ack);
        check("no ack for 0x43", {31'd0, ack}, 32'd1);
        check("not busy after mismatch", {31'd0, busy_o}, 32'd0);
        send_byte(8'hFF, -1, ack);
        check("no ack for data after mismatch", {31'd0, ack}, 32'd1);
        bus_stop();
        check("regs unchanged after mismatch", regs_o, 32'h113C_A522);

        // reset while presenting bit 7 (=0) of regs[0]=0x22
        bus_start();
        send_byte({TGT, 1'b1}, -1, ack);
        check("addr ack before reset", {31'd0, ack}, 32'd0);
        check("driving low before reset", {31'd0, sda_oe_o}, 32'd1);
        rst_ni = 1'b0;
        model_regs = '{default: '0};
        model_ptr  = '0;
        #1;
        check("sda released by reset", {31'd0, sda_oe_o}, 32'd0);
        check("busy cleared by reset", {31'd0, busy_o}, 32'd0);
        check("wr_idx cleared by reset", {30'd0, wr_idx_o}, 32'd0);
        #(CLK - 1);
        #(5*CLK);
        check("regs cleared by reset", regs_o, 32'd0);
        rst_ni = 1'b1;
        #(Q);
        bus_stop();
        write_regs(8'h00, 1, 8'h77, 8'h00, 1, -1);
        write_regs(8'h00, 0, 8'h00, 8'h00, 0, -1);
        read_regs(1, r0, r1);
        check("readback after reset literal", {24'd0, r0}, 32'h0000_0077);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // 1-clk SCL low glitch during bit 3 of the data byte
        write_regs(8'h01, 1, 8'h5A, 8'h00, 1, 3);
        check("glitch byte literal", {24'd0, regs_o[15:8]}, 32'h0000_005A);
        exp_pulses = 6;
`endif

        #(4*CLK);
        check("pending writes", exp_q.size(), 32'd0);
        check("pulse count", pulse_cnt, exp_pulses);
        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
